// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - mode constants and output-stage state encoding for muxn_arb
package muxn_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting at ptr
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int  NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    // One extra bit so ptr + offset can exceed NCH before the wrap.
    logic [SELW:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr} + (SELW + 1)'(i);
            if (cand >= (SELW + 1)'(NCH)) begin
                cand = cand - (SELW + 1)'(NCH);
            end
            if (!gnt_vld && req[cand[SELW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/muxn_arb.sv
// rtl/muxn_arb.sv - N-channel mux with fixed or round-robin grant into a one-word output register
module muxn_arb
    import muxn_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t            state;
    state_t            state_nxt;
    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   ptr_nxt;
    logic [SELW-1:0]   rr_idx;
    logic              rr_vld;
    logic [SELW-1:0]   gnt_idx;
    logic              gnt_vld;
    logic              can_load;
    logic              xfer;
    logic [WIDTH-1:0]  gnt_data;

    rr_arbiter #(
        .NCH(NCH)
    ) u_rr (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    assign out_valid = (state == ST_FULL);
    assign can_load  = (state == ST_EMPTY) || out_ready;

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end else begin
            gnt_idx = sel;
            gnt_vld = ({1'b0, sel} < (SELW + 1)'(NCH));
        end
    end

    // Ready is a function of grant and output state only, never of in_data.
    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == SELW'(k)) begin
                in_ready[k] = rst_n && gnt_vld && can_load;
                gnt_data    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer    = |(in_ready & in_valid);
    assign ptr_nxt = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (xfer) state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !xfer) state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                out_data <= gnt_data;
                out_ch   <= gnt_idx;
                if (mode == MODE_RR) begin
                    ptr <= ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
// tb/tb_muxn_arb.sv - scoreboard bench for muxn_arb with directed vectors
module tb_muxn_arb;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    typedef struct packed {
        logic [SELW-1:0]  ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    logic [5*WIDTH-1:0]   in_data5;
    logic [4:0]           in_valid5;
    logic [4:0]           in_ready5;
    logic                 mode5;
    logic [2:0]           sel5;
    logic [WIDTH-1:0]     out_data5;
    logic [2:0]           out_ch5;
    logic                 out_valid5;
    logic                 out_ready5;

    exp_t q[$];
    exp_t e;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    muxn_arb #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Five channels so a 3-bit sel can point past the last channel.
    muxn_arb #(.WIDTH(WIDTH), .NCH(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [WIDTH-1:0] v);
        in_data[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_output: got ch %0d data %0h, expected no word", out_ch, out_data);
            end else begin
                e = q.pop_front();
                chk("out_word", {out_ch, out_data}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_seq[4];
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 4'hf;
        mode       = 1'b0;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data5   = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
        in_valid5  = '0;
        mode5      = 1'b0;
        sel5       = 3'd0;
        out_ready5 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        next_cycle();

        // Fixed select of channel 2
        rst_n    = 1'b1;
        in_valid = 4'b0100;
        sel      = 2'd2;
        set_data(2, 8'hA5);
        @(negedge clk);
        chk("fix_in_ready", in_ready, 4'b0100);
        q.push_back({2'd2, 8'hA5});
        next_cycle();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("fix_out_valid", out_valid, 1);
        next_cycle();
        @(negedge clk);
        chk("drain_empty", out_valid, 0);
        chk("hold_data", out_data, 8'hA5);
        chk("hold_ch", out_ch, 2);
        next_cycle();

        // Round robin, all valid, back-to-back
        for (int k = 0; k < NCH; k++) set_data(k, 8'h10 + 8'(k));
        mode     = 1'b1;
        in_valid = 4'hf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_all_in_ready", in_ready, 4'b0001 << (i % 4));
            if (i > 0) chk("rr_no_bubble", out_valid, 1);
            q.push_back({2'(i % 4), 8'h10 + 8'(i % 4)});
            next_cycle();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk("rr_last_valid", out_valid, 1);
        next_cycle();

        // Move ptr to 2 via ch1, then alternate ch1/ch3
        set_data(1, 8'h21);
        set_data(3, 8'h23);
        in_valid = 4'b0010;
        @(negedge clk);
        chk("rr_ptr_setup", in_ready, 4'b0010);
        q.push_back({2'd1, 8'h21});
        next_cycle();
        rr_seq   = '{3, 1, 3, 1};
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_sparse_in_ready", in_ready, 4'b0001 << rr_seq[i]);
            q.push_back({2'(rr_seq[i]), (rr_seq[i] == 3) ? 8'h23 : 8'h21});
            next_cycle();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        next_cycle();

        // Stall with out_ready low while inputs toggle
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b0;
        set_data(0, 8'h33);
        in_valid  = 4'b0001;
        @(negedge clk);
        chk("stall_load_ready", in_ready, 4'b0001);
        q.push_back({2'd0, 8'h33});
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 1) ? 4'hf : 4'h5;
            set_data(0, 8'h40 + 8'(i));
            sel  = 2'(i % 4);
            mode = 1'(i % 2);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 8'h33);
            chk("stall_ch", out_ch, 0);
            chk("stall_in_ready", in_ready, 0);
            next_cycle();
        end
        mode      = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("stall_once", out_valid, 0);
        next_cycle();

        // Reset while FULL discards the word and clears ptr
        sel       = 2'd1;
        out_ready = 1'b0;
        set_data(1, 8'h77);
        in_valid  = 4'b0010;
        @(negedge clk);
        chk("prerst_in_ready", in_ready, 4'b0010);
        next_cycle();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hf;
        @(negedge clk);
        chk("inrst_in_ready", in_ready, 0);
        next_cycle();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_ch", out_ch, 0);
        next_cycle();
        rst_n = 1'b1;
        mode  = 1'b1;
        for (int k = 0; k < NCH; k++) set_data(k, 8'h50 + 8'(k));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("postrst_in_ready", in_ready, 4'b0001 << i);
            q.push_back({2'(i), 8'h50 + 8'(i)});
            next_cycle();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        next_cycle();

        // Out-of-range fixed select grants nothing
        in_valid5 = 5'h1f;
        for (int s = 5; s < 8; s++) begin
            sel5 = 3'(s);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk("oor_in_ready", in_ready5, 0);
                chk("oor_out_valid", out_valid5, 0);
                next_cycle();
            end
        end
        sel5 = 3'd4;
        @(negedge clk);
        chk("sel4_in_ready", in_ready5, 5'b10000);
        next_cycle();
        sel5 = 3'd5;
        @(negedge clk);
        chk("sel4_out_valid", out_valid5, 1);
        chk("sel4_out_ch", out_ch5, 4);
        chk("sel4_out_data", out_data5, 8'hC4);
        next_cycle();

        repeat (3) next_cycle();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
